// File: rtl/commit_trace_uart_tx_if.sv
// Trace capture and serial-out bundle for commit_trace_uart_tx.
// The master side drives the per-slot commit results. The slave side (the transmitter)
// returns the UART pin and its status.
interface commit_trace_uart_tx_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             slot1_valid;
    logic [31:0]      slot1_data;
    logic             slot2_valid;
    logic [31:0]      slot2_data;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output slot1_valid, slot1_data, slot2_valid, slot2_data,
        input  tx, busy, overflow, fifo_level
    );

    modport slave (
        input  slot1_valid, slot1_data, slot2_valid, slot2_data,
        output tx, busy, overflow, fifo_level
    );
endinterface

// File: rtl/commit_trace_uart_tx.sv
// Commit trace transmitter. It queues the per-slot ALU results and serialises each one
// as a framed 8N1 UART byte stream: A5, {slot_id,seq}, data[31:24] .. data[7:0].
// Optional feature macro TRACE_CHECKSUM_EN appends a seventh byte. That byte is the XOR
// of the six frame bytes.
module commit_trace_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    commit_trace_uart_tx_if.slave  bus
);
    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = ADDR_W + 1;
    localparam int unsigned ENTRY_W = 40;
    localparam int unsigned TICK_W  = $clog2(CLKS_PER_BIT);
`ifdef TRACE_CHECKSUM_EN
    localparam int unsigned NBYTES  = 7;
`else
    localparam int unsigned NBYTES  = 6;
`endif
    localparam int unsigned FRAME_W = NBYTES * 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr2_c;
    logic [LVL_W-1:0]   level_q, free_c, n_push_c;
    logic [6:0]         seq_q, seq2_c;
    logic               ovf_q, push1_c, push2_c, drop_c, pop_c;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [2:0]         bit_q, bit_d, byte_q, byte_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tx_q, tx_d, busy_q, busy_d;
    logic [7:0]         cur_byte_c;
    logic               tick_end_c;

    function automatic logic [FRAME_W-1:0] build_frame(input logic [ENTRY_W-1:0] e);
        logic [47:0] base;
        base = {8'hA5, e};
`ifdef TRACE_CHECKSUM_EN
        return {base, base[47:40] ^ base[39:32] ^ base[31:24]
                    ^ base[23:16] ^ base[15:8]  ^ base[7:0]};
`else
        return base;
`endif
    endfunction

    // Admission: the free count is taken before this cycle's pop, and slot 1 has priority.
    always_comb begin
        free_c    = LVL_W'(FIFO_DEPTH) - level_q;
        push1_c   = bus.slot1_valid && (free_c != '0);
        push2_c   = bus.slot2_valid && (free_c > LVL_W'(push1_c));
        drop_c    = (bus.slot1_valid && !push1_c) || (bus.slot2_valid && !push2_c);
        n_push_c  = LVL_W'(push1_c) + LVL_W'(push2_c);
        wr_ptr2_c = wr_ptr_q + ADDR_W'(push1_c);
        seq2_c    = seq_q + 7'(push1_c);
    end

    // Entry storage. It has no reset; only locations covered by the level count are read.
    always_ff @(posedge clk) begin
        if (push1_c) mem[wr_ptr_q] <= {1'b0, seq_q, bus.slot1_data};
        if (push2_c) mem[wr_ptr2_c] <= {1'b1, seq2_c, bus.slot2_data};
    end

    // FIFO pointers, level, sequence counter and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            seq_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(n_push_c);
            rd_ptr_q <= rd_ptr_q + ADDR_W'(pop_c);
            level_q  <= level_q + n_push_c - LVL_W'(pop_c);
            seq_q    <= seq_q + 7'(n_push_c);
            ovf_q    <= ovf_q | drop_c;
        end
    end

    assign cur_byte_c = frame_q[FRAME_W-1 -: 8];
    assign tick_end_c = (tick_q == TICK_W'(CLKS_PER_BIT - 1));

    // Serialiser next state. Frames go out back to back while entries are waiting.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (level_q != '0) begin
                    pop_c   = 1'b1;
                    frame_d = build_frame(mem[rd_ptr_q]);
                    byte_d  = 3'd0;
                    tick_d  = '0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_end_c) begin
                    tick_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = cur_byte_c[0];
                    state_d = DATA;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_end_c) begin
                    tick_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte_c[bit_q + 3'd1];
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_end_c) begin
                    tick_d = '0;
                    if (byte_q != 3'(NBYTES - 1)) begin
                        byte_d  = byte_q + 3'd1;
                        frame_d = frame_q << 8;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else if (level_q != '0) begin
                        pop_c   = 1'b1;
                        frame_d = build_frame(mem[rd_ptr_q]);
                        byte_d  = 3'd0;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serialiser state register. The registered tx and busy outputs live here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            frame_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_commit_trace_uart_tx.sv
// Bench for commit_trace_uart_tx. It uses directed scenarios plus random traffic.
// The reference model keeps the queued entries in a plain queue. It times each frame
// with a countdown of its length, and predicts tx by the frame position from arithmetic.
// A UART receiver decodes the serial pin on its own, without the model.
module tb_commit_trace_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef TRACE_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int FRAME_CYC = NB * 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    commit_trace_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    commit_trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [39:0] m_q[$];
    logic [39:0] m_sent[$];
    logic [7:0]  m_bytes [7];
    int          m_seq = 0;
    int          m_remain = 0;
    bit          m_busy = 0;
    bit          m_ovf = 0;
    bit          m_init = 0;
    int          max_lvl = 0;

    task automatic load_frame(input logic [39:0] e);
        m_bytes[0] = 8'hA5;
        m_bytes[1] = e[39:32];
        m_bytes[2] = e[31:24];
        m_bytes[3] = e[23:16];
        m_bytes[4] = e[15:8];
        m_bytes[5] = e[7:0];
        m_bytes[6] = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3] ^ m_bytes[4] ^ m_bytes[5];
    endtask

    task automatic model_step();
        int  lvl_pre;
        int  free;
        bit  do_pop;
        if (rst) begin
            m_q.delete();
            m_sent.delete();
            m_seq    = 0;
            m_ovf    = 0;
            m_busy   = 0;
            m_remain = 0;
            m_init   = 1;
        end else if (m_init) begin
            lvl_pre = m_q.size();
            free    = DEPTH - lvl_pre;
            do_pop  = (lvl_pre > 0) && (!m_busy || m_remain == 1);
            if (m_busy) begin
                if (m_remain == 1) m_busy = 0;
                else m_remain--;
            end
            if (do_pop) begin
                m_sent.push_back(m_q[0]);
                load_frame(m_q.pop_front());
                m_busy   = 1;
                m_remain = FRAME_CYC;
            end
            if (bus.slot1_valid) begin
                if (free > 0) begin
                    m_q.push_back({1'b0, 7'(m_seq), bus.slot1_data});
                    m_seq = (m_seq + 1) % 128;
                    free--;
                end else m_ovf = 1;
            end
            if (bus.slot2_valid) begin
                if (free > 0) begin
                    m_q.push_back({1'b1, 7'(m_seq), bus.slot2_data});
                    m_seq = (m_seq + 1) % 128;
                    free--;
                end else m_ovf = 1;
            end
        end
    endtask

    function automatic logic exp_tx();
        int el, bn, by, b;
        if (!m_busy) return 1'b1;
        el = FRAME_CYC - m_remain;
        bn = el / CPB;
        by = bn / 10;
        b  = bn % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_bytes[by][b-1];
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare the pin and the status against the model in every cycle.
    initial forever begin
        @(negedge clk);
        if (m_init) begin
            check_eq("tx",         32'(bus.tx),         32'(exp_tx()));
            check_eq("busy",       32'(bus.busy),       32'(m_busy));
            check_eq("overflow",   32'(bus.overflow),   32'(m_ovf));
            check_eq("fifo_level", 32'(bus.fifo_level), 32'(m_q.size()));
            if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
        end
    end

    // ---------------- independent UART receiver ----------------
    logic [7:0] rx_q[$];

    initial forever begin
        logic [7:0] b;
        @(negedge clk);
        if (bus.tx === 1'b0 && !rst) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = bus.tx;
            end
            repeat (CPB) @(negedge clk);
            rx_q.push_back(b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2);
        @(negedge clk);
        bus.slot1_valid = v1;
        bus.slot1_data  = d1;
        bus.slot2_valid = v2;
        bus.slot2_data  = d2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.slot1_valid = 1'b0;
        bus.slot2_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (!bus.busy && bus.fifo_level == '0 && bus.tx) break;
        end
        check_eq(tag, 32'(i < 40000), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    logic [7:0] exp2 [7];
    logic [7:0] t4_tags [5];

    initial begin
        int nbusy, acc, nfr;
        logic v;
        bus.slot1_valid = 1'b0;
        bus.slot1_data  = '0;
        bus.slot2_valid = 1'b0;
        bus.slot2_data  = '0;

        // 1: reset and idle
        do_reset();
        repeat (50) @(negedge clk);
        check_eq("t1_tx_idle", 32'(bus.tx), 32'd1);
        check_eq("t1_level", 32'(bus.fifo_level), 32'd0);

        // 2: single entry, latency, frame length, decoded bytes
        do_reset();
        rx_q.delete();
        cyc(1'b1, 32'h12345678, 1'b0, '0);
        cyc(1'b0, 32'h0BADF00D, 1'b0, '0);
        check_eq("t2_tx_at_capture", 32'(bus.tx), 32'd1);
        check_eq("t2_level_at_capture", 32'(bus.fifo_level), 32'd1);
        @(negedge clk);
        check_eq("t2_tx_start", 32'(bus.tx), 32'd0);
        check_eq("t2_busy_start", 32'(bus.busy), 32'd1);
        nbusy = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            else break;
        end
        check_eq("t2_busy_cycles", 32'(nbusy), 32'(FRAME_CYC));
        repeat (4) @(negedge clk);
        exp2 = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAD};
        check_eq("t2_rx_count", 32'(rx_q.size()), 32'(NB));
        for (int k = 0; k < NB; k++) check_eq("t2_rx_byte", 32'(rx_q[k]), 32'(exp2[k]));

        // 3: both slots at once, back-to-back frames
        do_reset();
        rx_q.delete();
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 32'h00000001);
        cyc(1'b0, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF);
        drain("t3_drain");
        check_eq("t3_rx_count", 32'(rx_q.size()), 32'(2 * NB));
        check_eq("t3_sync0", 32'(rx_q[0]), 32'hA5);
        check_eq("t3_tag0", 32'(rx_q[1]), 32'h00);
        check_eq("t3_data0", {rx_q[2], rx_q[3], rx_q[4], rx_q[5]}, 32'hDEADBEEF);
        check_eq("t3_sync1", 32'(rx_q[NB]), 32'hA5);
        check_eq("t3_tag1", 32'(rx_q[NB+1]), 32'h81);
        check_eq("t3_data1", {rx_q[NB+2], rx_q[NB+3], rx_q[NB+4], rx_q[NB+5]}, 32'h00000001);

        // 4: overflow while busy
        do_reset();
        rx_q.delete();
        max_lvl = 0;
        cyc(1'b1, 32'h11111111, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, '0);
        repeat (3) cyc(1'b1, $urandom, 1'b1, $urandom);
        cyc(1'b0, '0, 1'b0, '0);
        check_eq("t4_overflow", 32'(bus.overflow), 32'd1);
        check_eq("t4_level_full", 32'(bus.fifo_level), 32'(DEPTH));
        drain("t4_drain");
        check_eq("t4_rx_count", 32'(rx_q.size()), 32'(5 * NB));
        t4_tags = '{8'h00, 8'h01, 8'h82, 8'h03, 8'h84};
        for (int k = 0; k < 5; k++) check_eq("t4_tag", 32'(rx_q[k*NB+1]), 32'(t4_tags[k]));
        check_eq("t4_overflow_sticky", 32'(bus.overflow), 32'd1);
        check_eq("t4_max_level", 32'(max_lvl <= DEPTH), 32'd1);

        // random traffic: sparse, then dense enough to overflow
        do_reset();
        rx_q.delete();
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = (k < 1500) ? 400 : 60;
            cyc($urandom_range(0, r - 1) == 0, $urandom, $urandom_range(0, r - 1) == 0, $urandom);
        end
        cyc(1'b0, '0, 1'b0, '0);
        drain("rnd_drain");
        nfr = m_sent.size();
        check_eq("rnd_rx_count", 32'(rx_q.size()), 32'(nfr * NB));
        for (int k = 0; k < nfr; k++) begin
            check_eq("rnd_sync", 32'(rx_q[k*NB]), 32'hA5);
            check_eq("rnd_tag", 32'(rx_q[k*NB+1]), 32'(m_sent[k][39:32]));
            check_eq("rnd_data", {rx_q[k*NB+2], rx_q[k*NB+3], rx_q[k*NB+4], rx_q[k*NB+5]},
                     m_sent[k][31:0]);
        end

        // 6: reset in the middle of the data bits of the third byte
        rx_q.delete();
        cyc(1'b1, 32'hCAFEF00D, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, '0);
        repeat (95) @(negedge clk);
        check_eq("t6_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_tx_reset", 32'(bus.tx), 32'd1);
        check_eq("t6_busy_reset", 32'(bus.busy), 32'd0);
        check_eq("t6_level_reset", 32'(bus.fifo_level), 32'd0);
        check_eq("t6_ovf_reset", 32'(bus.overflow), 32'd0);
        repeat (60) @(negedge clk);
        rx_q.delete();
        cyc(1'b1, 32'h0F0F0F0F, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, '0);
        drain("t6_drain");
        check_eq("t6_rx_count", 32'(rx_q.size()), 32'(NB));
        check_eq("t6_sync", 32'(rx_q[0]), 32'hA5);
        check_eq("t6_tag", 32'(rx_q[1]), 32'h00);
        check_eq("t6_data", {rx_q[2], rx_q[3], rx_q[4], rx_q[5]}, 32'h0F0F0F0F);

        // 5: 130 accepted entries, sequence wraps
        do_reset();
        rx_q.delete();
        acc = 0;
        for (int it = 0; it < 45000 && acc < 130; it++) begin
            v = (m_q.size() <= 2) && ($urandom_range(0, 3) == 0);
            cyc(v, $urandom, 1'b0, '0);
            if (v) acc++;
        end
        cyc(1'b0, '0, 1'b0, '0);
        check_eq("t5_accepted", 32'(acc), 32'd130);
        drain("t5_drain");
        check_eq("t5_rx_count", 32'(rx_q.size()), 32'(130 * NB));
        for (int k = 0; k < 130; k++) begin
            check_eq("t5_sync", 32'(rx_q[k*NB]), 32'hA5);
            check_eq("t5_tag_seq", 32'(rx_q[k*NB+1]), 32'(k % 128));
        end
        check_eq("t5_no_overflow", 32'(bus.overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
